// File: rtl/ula_pkg.sv
// Shared definitions for the registered ALU: operation codes and FSM states.
package ula_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_SHL  = 3'b011;
   localparam logic [2:0] OP_SHR  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done pulses for one cycle once prod holds the full 2*WIDTH-bit product.
module ula_mul_seq #(
   parameter int WIDTH = 16
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 start,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Next-state: latch operands on start, otherwise one shift-add step per cycle
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, A};
         mplier_d = B;
         acc_d    = '0;
         cnt_d    = CW'(WIDTH);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // State registers; reset aborts any multiplication in flight
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign prod = acc_q;

endmodule

// File: rtl/ula_seq.sv
// Registered ALU with valid/ready on both sides, status flags and a
// multi-cycle multiplier. Single-cycle ops land one edge after accept,
// MUL lands WIDTH+1 edges after accept.
module ula_seq
   import ula_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             Clock,
   input  logic             ResetN,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OpSelect,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Resul,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow,
   output logic             Busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic               run_q;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   resul_q, resul_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic [SHW-1:0]     sh_amt;
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;

   logic               accept;
   logic               is_mul_op;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   assign sh_amt    = B[SHW-1:0];
   assign is_mul_op = MUL_EN && (OpSelect == OP_MUL);

   // run_q keeps InReady low while reset is held and for the first edge after it
   assign InReady = run_q && (state_q == S_IDLE) && (!out_valid_q || OutReady);
   assign accept  = InValid && InReady;

   // Single-cycle datapath: result, carry and overflow for the selected op
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum_ext = '0;
      shl_ext = '0;
      shr_ext = '0;
      case (OpSelect)
         OP_ADD: begin
            sum_ext = {1'b0, A} + {1'b0, B};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            // Bit WIDTH of the extended difference is the borrow (A < B unsigned)
            sum_ext = {1'b0, A} - {1'b0, B};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
         end
         OP_NAND: begin
            alu_res = ~(A & B);
         end
         OP_SHL: begin
            // The extra top bit catches the last bit shifted out (0 for amount 0)
            shl_ext = {1'b0, A} << sh_amt;
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            // The extra bottom bit catches the last bit shifted out (0 for amount 0)
            shr_ext = {A, 1'b0} >> sh_amt;
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         OP_MUL: begin
            // Only reaches the output when the multiplier is not built
            alu_res = '0;
         end
         OP_SLT: begin
            alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         end
         OP_PASS: begin
            alu_res = B;
         end
         default: begin
            alu_res = '0;
         end
      endcase
   end

   generate
      if (MUL_EN) begin : g_mul
         ula_mul_seq #(
            .WIDTH (WIDTH)
         ) u_mul (
            .Clock  (Clock),
            .ResetN (ResetN),
            .start  (accept && is_mul_op),
            .A      (A),
            .B      (B),
            .busy   (mul_busy),
            .done   (mul_done),
            .prod   (mul_prod)
         );
      end else begin : g_nomul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign mul_prod = '0;
      end
   endgenerate

   // FSM and output stage: hold while stalled, drain on OutReady, load on accept or MUL done
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !OutReady;
      resul_d     = resul_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul_op) begin
                  state_d = S_MUL;
               end else begin
                  out_valid_d = 1'b1;
                  resul_d     = alu_res;
                  zero_d      = (alu_res == '0);
                  neg_d       = alu_res[WIDTH-1];
                  carry_d     = alu_c;
                  ovf_d       = alu_v;
               end
            end
         end
         S_MUL: begin
            if (mul_done) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b1;
               resul_d     = mul_prod[WIDTH-1:0];
               zero_d      = (mul_prod[WIDTH-1:0] == '0);
               neg_d       = mul_prod[WIDTH-1];
               carry_d     = |mul_prod[2*WIDTH-1:WIDTH];
               ovf_d       = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset clears every output and drops any MUL
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= S_IDLE;
         run_q       <= 1'b0;
         out_valid_q <= 1'b0;
         resul_q     <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= 1'b1;
         out_valid_q <= out_valid_d;
         resul_q     <= resul_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
      end
   end

   assign OutValid = out_valid_q;
   assign Resul    = resul_q;
   assign Zero     = zero_q;
   assign Negative = neg_q;
   assign Carry    = carry_q;
   assign Overflow = ovf_q;
   assign Busy     = mul_busy || (state_q == S_MUL);

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: stimulus pushes expected results, a monitor
// pops and compares whenever a result is taken. A second instance is built
// without the multiplier.
module tb_ula_seq;
   import ula_pkg::*;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic         z;
      logic         n;
      logic         c;
      logic         v;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_valid1 = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   op = 3'b000;

   logic         in_ready, out_valid, zero, neg, carry, ovf, busy;
   logic [W-1:0] resul;
   logic         in_ready1, out_valid1, zero1, neg1, carry1, ovf1, busy1;
   logic [W-1:0] resul1;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_vec = 0;
   int    n_err = 0;

   always #5 clk = ~clk;

   ula_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .Clock(clk), .ResetN(rst_n), .InValid(in_valid), .InReady(in_ready),
      .A(a), .B(b), .OpSelect(op), .OutValid(out_valid), .OutReady(out_ready),
      .Resul(resul), .Zero(zero), .Negative(neg), .Carry(carry),
      .Overflow(ovf), .Busy(busy)
   );

   ula_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
      .Clock(clk), .ResetN(rst_n), .InValid(in_valid1), .InReady(in_ready1),
      .A(a), .B(b), .OpSelect(op), .OutValid(out_valid1), .OutReady(out_ready),
      .Resul(resul1), .Zero(zero1), .Negative(neg1), .Carry(carry1),
      .Overflow(ovf1), .Busy(busy1)
   );

   function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic n,
                               input logic c, input logic v);
      exp_t e;
      e.res = r;
      e.z   = z;
      e.n   = n;
      e.c   = c;
      e.v   = v;
      return e;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Wait (bounded) for InReady with the current operands, then record the expectation
   task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input exp_t e);
      int k;
      op = o;
      a  = x;
      b  = y;
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         check({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
      end else begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each result as the consumer takes it
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got resul=%h, required no output", resul);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               check(nm, 32'({resul, zero, neg, carry, ovf}), 32'(e));
               $display("txn %-16s resul=%h z=%b n=%b c=%b v=%b (want %h %b%b%b%b)",
                        nm, resul, zero, neg, carry, ovf, e.res, e.z, e.n, e.c, e.v);
            end
         end
      end
   end

   initial begin
      int lat;
      int bad;
      int k;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({in_ready, out_valid, resul, zero, neg, carry, ovf, busy}), 32'd0);
      check("reset_outputs_nomul",
            32'({in_ready1, out_valid1, resul1, zero1, neg1, carry1, ovf1, busy1}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single-cycle ops and multiplies, consumer always ready
      issue("add_ovf",    OP_ADD,  16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
      issue("add_carry",  OP_ADD,  16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
      issue("sub_borrow", OP_SUB,  16'h0003, 16'h0005, mk(16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0));
      issue("sub_ovf",    OP_SUB,  16'h8000, 16'h0001, mk(16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1));
      issue("slt_true",   OP_SLT,  16'hFFFF, 16'h0001, mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
      issue("slt_false",  OP_SLT,  16'h0001, 16'hFFFF, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
      issue("nand_zero",  OP_NAND, 16'hFFFF, 16'hFFFF, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
      issue("pass",       OP_PASS, 16'h1234, 16'hABCD, mk(16'hABCD, 1'b0, 1'b1, 1'b0, 1'b0));
      issue("shl_out",    OP_SHL,  16'h8001, 16'h0001, mk(16'h0002, 1'b0, 1'b0, 1'b1, 1'b0));
      issue("shl_15",     OP_SHL,  16'h0001, 16'h000F, mk(16'h8000, 1'b0, 1'b1, 1'b0, 1'b0));
      issue("shr_zero",   OP_SHR,  16'h1234, 16'h0010, mk(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
      issue("shr_out",    OP_SHR,  16'h8001, 16'h0001, mk(16'h4000, 1'b0, 1'b0, 1'b1, 1'b0));
      issue("shr_15",     OP_SHR,  16'h8000, 16'h000F, mk(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0));
      issue("mul_7x9",    OP_MUL,  16'h0007, 16'h0009, mk(16'h003F, 1'b0, 1'b0, 1'b0, 1'b0));
      issue("mul_max",    OP_MUL,  16'hFFFF, 16'hFFFF, mk(16'h0001, 1'b0, 1'b0, 1'b1, 1'b0));
      drain();

      // MUL latency and InReady low while busy
      op = OP_MUL;
      a  = 16'h0100;
      b  = 16'h0101;
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("mul_accept_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(mk(16'h0100, 1'b0, 1'b0, 1'b1, 1'b0));
      name_q.push_back("mul_0100x0101");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      bad = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
         if (!busy || in_ready) bad++;
      end
      check("mul_latency", 32'(lat), 32'd17);
      check("mul_busy_blocks_ready", 32'(bad), 32'd0);
      check("mul_busy_cleared", 32'(busy), 32'd0);
      drain();

      // Backpressure: second op held off, then drain and accept in the same cycle
      out_ready = 1'b0;
      issue("bp_add", OP_ADD, 16'h0001, 16'h0002, mk(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
      op = OP_NAND;
      a  = 16'h00F0;
      b  = 16'h0FF0;
      in_valid = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (in_ready) bad++;
         if (!out_valid || resul !== 16'h0003) bad++;
      end
      check("bp_holdoff", 32'(bad), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(mk(16'hFF0F, 1'b0, 1'b1, 1'b0, 1'b0));
      name_q.push_back("bp_nand");
      @(negedge clk);
      check("bp_drain_accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_reload_valid", 32'(out_valid), 32'd1);
      drain();

      // Reset in the middle of a multiply
      op = OP_MUL;
      a  = 16'h0007;
      b  = 16'h0009;
      in_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_mul", 32'({out_valid, busy, in_ready}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_ready", 32'(in_ready), 32'd1);
      bad = 0;
      repeat (25) begin
         @(negedge clk);
         if (out_valid || busy) bad++;
      end
      check("rst_no_stale", 32'(bad), 32'd0);

      // Build without multiplier: op 101 gives 0 in one cycle
      @(posedge clk);
      #1;
      op = OP_MUL;
      a  = 16'h0007;
      b  = 16'h0009;
      in_valid1 = 1'b1;
      @(negedge clk);
      check("nomul_ready", 32'(in_ready1), 32'd1);
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      check("nomul_result",
            32'({out_valid1, resul1, zero1, neg1, carry1, ovf1, busy1}),
            32'({1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      $display("txn %-16s resul=%h z=%b c=%b valid=%b", "nomul_op101", resul1, zero1, carry1, out_valid1);

      drain();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
